// File: rtl/cc_event_mux_if.sv
// Receive-side event stream bundle: foreign event lines in, granted channel stream
// and per-channel drop accounting out.
interface cc_event_mux_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       evt_in;
  logic               evt_valid;
  logic               evt_ready;
  logic [CHW-1:0]     evt_chan;
  logic [N-1:0]       pending;
  logic [N-1:0]       drop_pulse;
  logic [N*CNT_W-1:0] drop_cnt;
  logic               drop_cnt_clr;

  modport master (
    input  evt_in, evt_ready, drop_cnt_clr,
    output evt_valid, evt_chan, pending, drop_pulse, drop_cnt
  );

  modport slave (
    output evt_in, evt_ready, drop_cnt_clr,
    input  evt_valid, evt_chan, pending, drop_pulse, drop_cnt
  );
endinterface

// File: rtl/cc_event_mux.sv
// N-channel cross-clock event receiver: synchronise, latch one pending event per
// channel, and present them round-robin on a valid/ready stream with drop counting.
module cc_event_mux #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst,
  cc_event_mux_if.master bus
);
  localparam int CHW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]            s, p_q, det;
  logic [N-1:0]            pend_q, pend_d;
  logic                    valid_q, valid_d;
  logic [CHW-1:0]          chan_q, chan_d, ptr_q, ptr_d;
  logic [N-1:0]            drop, drop_q;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                    load, found;
  logic [2*N-1:0]          pend_rot;
  logic [CHW-1:0]          off, grant;
  logic [CHW:0]            gsum;
  logic [N-1:0]            gnt_oh;

  assign s    = sync_q[SYNC_STAGES-1];
  assign det  = (MODE == 0) ? (s ^ p_q) : (s & ~p_q);
  assign load = !valid_q || bus.evt_ready;

  // Rotate pending so bit 0 is the RR pointer; the lowest set bit is the grant offset.
  assign pend_rot = {pend_q, pend_q} >> ptr_q;

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        found = 1'b1;
        off   = CHW'(k);
      end
    end
    gsum  = {1'b0, ptr_q} + {1'b0, off};
    grant = (gsum >= (CHW+1)'(N)) ? CHW'(gsum - (CHW+1)'(N)) : CHW'(gsum);
  end

  always_comb begin
    valid_d = valid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    gnt_oh  = '0;
    if (load) begin
      if (found) begin
        valid_d = 1'b1;
        chan_d  = grant;
        ptr_d   = (grant == CHW'(N - 1)) ? '0 : grant + 1'b1;
        gnt_oh  = N'(1) << grant;
      end else begin
        valid_d = 1'b0;
      end
    end
    // A channel being granted this cycle frees its slot, so a coincident event re-latches instead of dropping.
    drop   = det & pend_q & ~gnt_oh;
    pend_d = (pend_q & ~gnt_oh) | det;
    cnt_d  = cnt_q;
    for (int i = 0; i < N; i++) begin
      if (bus.drop_cnt_clr)
        cnt_d[i] = drop[i] ? CNT_W'(1) : '0;
      else if (drop[i] && (cnt_q[i] != CNT_MAX))
        cnt_d[i] = cnt_q[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      p_q     <= '0;
      pend_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= '0;
      drop_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.evt_in};
      p_q     <= s;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.evt_valid  = valid_q;
  assign bus.evt_chan   = chan_q;
  assign bus.pending    = pend_q;
  assign bus.drop_pulse = drop_q;
  assign bus.drop_cnt   = cnt_q;
endmodule
